link_constraint: RTL and testbench

LINK_CONSTRAINT -- requirements
Module: link_constraint

---
 rtl/link_constraint.sv | 195 +++++++++++++++++++
 tb/tb_link_constraint.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_constraint.sv
// Distance constraint between two nodes: pulls/pushes A and B toward REST_LEN separation.
// Define LINK_PIN_A_EN to anchor node A and apply the full correction to node B.
module link_constraint #(
   parameter int unsigned REST_LEN = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [31:0] in_ax,
   input  logic signed [31:0] in_ay,
   input  logic signed [31:0] in_bx,
   input  logic signed [31:0] in_by,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [31:0] out_ax,
   output logic signed [31:0] out_ay,
   output logic signed [31:0] out_bx,
   output logic signed [31:0] out_by,
   output logic               busy
);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StSq   = 3'd1,
      StSqrt = 3'd2,
      StMul  = 3'd3,
      StDiv  = 3'd4,
      StDone = 3'd5
   } state_e;

   state_e state_q, state_d;

   logic signed [31:0] ax_q, ay_q, bx_q, by_q;
   logic signed [15:0] dx_q, dy_q;
   logic        [31:0] rad_q;
   logic        [17:0] rem_q;
   logic        [15:0] root_q;
   logic        [4:0]  cnt_q;
   logic               sx_q, sy_q;
   logic        [31:0] qx_q, qy_q;
   logic        [17:0] rx_q, ry_q;
   logic        [17:0] divisor_q;

   function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
      if (v > 33'sd32767) return 16'sd32767;
      if (v < -33'sd32767) return -16'sd32767;
      return 16'(v);
   endfunction

   logic signed [32:0] dx_full, dy_full;
   logic signed [15:0] dx_sat, dy_sat;
   logic signed [31:0] dx_sat_e, dy_sat_e, dx_e, dy_e;
   logic        [31:0] d2;
   logic        [19:0] sq_trial_rem, sq_trial;
   logic               sq_take;
   logic        [17:0] rem_n;
   logic        [15:0] root_n;
   logic signed [31:0] diff, nx, ny;
   logic        [18:0] rx_trial, ry_trial;
   logic               rx_take, ry_take;
   logic        [17:0] rx_n, ry_n;
   logic        [31:0] qx_n, qy_n;
   logic signed [31:0] cx, cy;

   always_comb begin
      dx_full  = $signed({bx_q[31], bx_q}) - $signed({ax_q[31], ax_q});
      dy_full  = $signed({by_q[31], by_q}) - $signed({ay_q[31], ay_q});
      dx_sat   = sat16(dx_full);
      dy_sat   = sat16(dy_full);
      dx_sat_e = $signed({{16{dx_sat[15]}}, dx_sat});
      dy_sat_e = $signed({{16{dy_sat[15]}}, dy_sat});
      d2       = dx_sat_e * dx_sat_e + dy_sat_e * dy_sat_e;

      // Restoring square root: bring down two radicand bits, try appending a 1 to the root.
      sq_trial_rem = {rem_q, rad_q[31:30]};
      sq_trial     = {2'b00, root_q, 2'b01};
      sq_take      = sq_trial_rem >= sq_trial;
      rem_n        = sq_take ? 18'(sq_trial_rem - sq_trial) : 18'(sq_trial_rem);
      root_n       = {root_q[14:0], sq_take};

      dx_e = $signed({{16{dx_q[15]}}, dx_q});
      dy_e = $signed({{16{dy_q[15]}}, dy_q});
      diff = $signed({16'b0, root_q}) - $signed(REST_LEN);
      nx   = dx_e * diff;
      ny   = dy_e * diff;

      rx_trial = {rx_q, qx_q[31]};
      ry_trial = {ry_q, qy_q[31]};
      rx_take  = rx_trial >= {1'b0, divisor_q};
      ry_take  = ry_trial >= {1'b0, divisor_q};
      rx_n     = rx_take ? 18'(rx_trial - {1'b0, divisor_q}) : 18'(rx_trial);
      ry_n     = ry_take ? 18'(ry_trial - {1'b0, divisor_q}) : 18'(ry_trial);
      qx_n     = {qx_q[30:0], rx_take};
      qy_n     = {qy_q[30:0], ry_take};
      cx       = sx_q ? -$signed(qx_n) : $signed(qx_n);
      cy       = sy_q ? -$signed(qy_n) : $signed(qy_n);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (in_valid) state_d = StSq;
         StSq:    state_d = StSqrt;
         StSqrt:  if (cnt_q == 5'd15) state_d = (root_n == 16'd0) ? StDone : StMul;
         StMul:   state_d = StDiv;
         StDiv:   if (cnt_q == 5'd31) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ax_q <= '0; ay_q <= '0; bx_q <= '0; by_q <= '0;
         dx_q <= '0; dy_q <= '0;
         rad_q <= '0; rem_q <= '0; root_q <= '0; cnt_q <= '0;
         sx_q <= 1'b0; sy_q <= 1'b0;
         qx_q <= '0; qy_q <= '0; rx_q <= '0; ry_q <= '0; divisor_q <= '0;
         out_ax <= '0; out_ay <= '0; out_bx <= '0; out_by <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  ax_q <= in_ax; ay_q <= in_ay; bx_q <= in_bx; by_q <= in_by;
               end
            end
            StSq: begin
               dx_q   <= dx_sat;
               dy_q   <= dy_sat;
               rad_q  <= d2;
               rem_q  <= '0;
               root_q <= '0;
               cnt_q  <= '0;
            end
            StSqrt: begin
               rad_q  <= {rad_q[29:0], 2'b00};
               rem_q  <= rem_n;
               root_q <= root_n;
               cnt_q  <= cnt_q + 5'd1;
               // Coincident nodes: no direction to correct along, pass positions through.
               if (cnt_q == 5'd15 && root_n == 16'd0) begin
                  out_ax <= ax_q; out_ay <= ay_q; out_bx <= bx_q; out_by <= by_q;
               end
            end
            StMul: begin
               sx_q  <= nx[31];
               sy_q  <= ny[31];
               qx_q  <= nx[31] ? 32'(-nx) : 32'(nx);
               qy_q  <= ny[31] ? 32'(-ny) : 32'(ny);
               rx_q  <= '0;
               ry_q  <= '0;
               cnt_q <= '0;
`ifdef LINK_PIN_A_EN
               divisor_q <= {2'b00, root_q};
`else
               divisor_q <= {1'b0, root_q, 1'b0};
`endif
            end
            StDiv: begin
               rx_q  <= rx_n;
               ry_q  <= ry_n;
               qx_q  <= qx_n;
               qy_q  <= qy_n;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
`ifdef LINK_PIN_A_EN
                  out_ax <= ax_q;
                  out_ay <= ay_q;
`else
                  out_ax <= ax_q + cx;
                  out_ay <= ay_q + cy;
`endif
                  out_bx <= bx_q - cx;
                  out_by <= by_q - cy;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_link_constraint.sv
// Directed bench for link_constraint: geometry vectors, coincident path, handshake
// stalls, back-to-back handshake/accept and mid-operation reset.
module tb_link_constraint;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [31:0] in_ax = '0, in_ay = '0, in_bx = '0, in_by = '0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic signed [31:0] out_ax, out_ay, out_bx, out_by;
   logic               busy;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int NV = 7;
   int vin [NV][4] = '{
      '{200, 10, 200, 30},
      '{200, 10, 200, 14},
      '{0, 0, 3, 4},
      '{10, 20, 40, 60},
      '{10, 0, 40, 1},
      '{0, 0, 100000, 0},
      '{0, 0, 0, -100000}
   };
`ifdef LINK_PIN_A_EN
   int vexp [NV][4] = '{
      '{200, 10, 200, 20},
      '{200, 10, 200, 20},
      '{0, 0, 6, 8},
      '{10, 20, 16, 28},
      '{10, 0, 20, 1},
      '{0, 0, 67243, 0},
      '{0, 0, 0, -67243}
   };
`else
   int vexp [NV][4] = '{
      '{200, 15, 200, 25},
      '{200, 7, 200, 17},
      '{-1, -2, 4, 6},
      '{22, 36, 28, 44},
      '{20, 0, 30, 1},
      '{16378, 0, 83622, 0},
      '{0, -16378, 0, -83622}
   };
`endif

   link_constraint #(.REST_LEN(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ax     (in_ax),
      .in_ay     (in_ay),
      .in_bx     (in_bx),
      .in_by     (in_by),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ax    (out_ax),
      .out_ay    (out_ay),
      .out_bx    (out_bx),
      .out_by    (out_by),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Present one pair for a single accepting edge (E0); returns 1 ns after E0.
   task automatic start_pair(input int ax, input int ay, input int bx, input int by);
      @(negedge clk);
      in_ax = ax; in_ay = ay; in_bx = bx; in_by = by;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Edges counted after E0 until out_valid; -1 when the budget runs out.
   task automatic wait_out(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic release_out;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, busy, in_ready} !== 3'b001 || out_ax !== 0 || out_ay !== 0 ||
          out_bx !== 0 || out_by !== 0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b b=%b r=%b out=(%0d,%0d,%0d,%0d) want 0,0,1 zeros",
                  out_valid, busy, in_ready, out_ax, out_ay, out_bx, out_by);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_geometry;
      int lat;
      for (int i = 0; i < NV; i++) begin
         start_pair(vin[i][0], vin[i][1], vin[i][2], vin[i][3]);
         wait_out(lat);
         n_tests++;
         if (lat !== 50) begin
            n_fail++;
            $display("FAIL geom%0d_latency: got %0d want 50", i, lat);
         end
         n_tests++;
         if (out_ax !== vexp[i][0] || out_ay !== vexp[i][1] ||
             out_bx !== vexp[i][2] || out_by !== vexp[i][3]) begin
            n_fail++;
            $display("FAIL geom%0d_out: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", i,
                     out_ax, out_ay, out_bx, out_by,
                     vexp[i][0], vexp[i][1], vexp[i][2], vexp[i][3]);
         end
         release_out();
         n_tests++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL geom%0d_release: got out_valid=%b in_ready=%b want 0 1",
                     i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_coincident;
      int lat;
      start_pair(50, 50, 50, 50);
      wait_out(lat);
      n_tests++;
      if (lat !== 17) begin
         n_fail++;
         $display("FAIL coincident_latency: got %0d want 17", lat);
      end
      n_tests++;
      if (out_ax !== 50 || out_ay !== 50 || out_bx !== 50 || out_by !== 50) begin
         n_fail++;
         $display("FAIL coincident_out: got (%0d,%0d,%0d,%0d) want (50,50,50,50)",
                  out_ax, out_ay, out_bx, out_by);
      end
      release_out();
   endtask

   task automatic test_handshake;
      int lat;
      bit ready_bad, hold_bad;
      start_pair(200, 10, 200, 30);
      lat = -1;
      ready_bad = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         in_valid = (i % 4 == 1);
         in_ax = 777; in_ay = -777; in_bx = 1234; in_by = 5678;
         if (in_ready !== 1'b0) ready_bad = 1'b1;
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      in_valid = 1'b0;
      n_tests++;
      if (lat !== 50 || ready_bad) begin
         n_fail++;
         $display("FAIL busy_ignore: got latency=%0d in_ready_seen_high=%b want 50 0",
                  lat, ready_bad);
      end
      n_tests++;
      if (out_ax !== 200 || out_ay !== vexp[0][1] || out_bx !== 200 ||
          out_by !== vexp[0][3]) begin
         n_fail++;
         $display("FAIL busy_ignore_out: got (%0d,%0d,%0d,%0d) want (200,%0d,200,%0d)",
                  out_ax, out_ay, out_bx, out_by, vexp[0][1], vexp[0][3]);
      end
      hold_bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = (i % 2 == 0);
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_ax !== 200 ||
             out_ay !== vexp[0][1] || out_bx !== 200 || out_by !== vexp[0][3])
            hold_bad = 1'b1;
      end
      in_valid = 1'b0;
      n_tests++;
      if (hold_bad) begin
         n_fail++;
         $display("FAIL stall_hold: got outputs/out_valid changed want held for 20 cycles");
      end
      // Out handshake and a new pair on the same edge: only the handshake takes effect.
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ax = 200; in_ay = 10; in_bx = 200; in_by = 14;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_tests++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL same_edge: got v=%b b=%b r=%b want 0 0 1", out_valid, busy, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL next_accept: got busy=%b want 1", busy);
      end
      wait_out(lat);
      n_tests++;
      if (lat !== 50 || out_ay !== vexp[1][1] || out_by !== vexp[1][3]) begin
         n_fail++;
         $display("FAIL back_to_back: got lat=%0d ay=%0d by=%0d want 50 %0d %0d",
                  lat, out_ay, out_by, vexp[1][1], vexp[1][3]);
      end
      release_out();
   endtask

   task automatic test_reset_mid;
      int offs [2];
      int lat;
      bit early, stale;
      offs = '{9, 38};
      for (int k = 0; k < 2; k++) begin
         start_pair(200, 10, 200, 30);
         early = 1'b0;
         repeat (offs[k]) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) early = 1'b1;
         end
         #2;
         reset = 1'b1;
         #1;
         n_tests++;
         if ({out_valid, busy, in_ready} !== 3'b001 || early || out_ax !== 0 ||
             out_ay !== 0 || out_bx !== 0 || out_by !== 0) begin
            n_fail++;
            $display("FAIL reset_mid%0d: got v=%b b=%b r=%b early=%b out=(%0d,%0d,%0d,%0d)",
                     k, out_valid, busy, in_ready, early, out_ax, out_ay, out_bx, out_by);
         end
         @(negedge clk);
         reset = 1'b0;
         stale = 1'b0;
         repeat (60) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
         end
         n_tests++;
         if (stale) begin
            n_fail++;
            $display("FAIL reset_mid%0d_abandon: got stale activity want idle", k);
         end
         start_pair(0, 0, 3, 4);
         wait_out(lat);
         n_tests++;
         if (lat !== 50 || out_ax !== vexp[2][0] || out_ay !== vexp[2][1] ||
             out_bx !== vexp[2][2] || out_by !== vexp[2][3]) begin
            n_fail++;
            $display("FAIL reset_mid%0d_next: got lat=%0d (%0d,%0d,%0d,%0d) want 50 (%0d,%0d,%0d,%0d)",
                     k, lat, out_ax, out_ay, out_bx, out_by,
                     vexp[2][0], vexp[2][1], vexp[2][2], vexp[2][3]);
         end
         release_out();
      end
   endtask

   initial begin
      test_reset();
      test_geometry();
      test_coincident();
      test_handshake();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
